// File: rtl/regfile_wb_if.sv
// Write-back / read-port bundle for the register-file stage.
interface regfile_wb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          wb_en;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          stall;
  logic          flush;
  logic [AW-1:0] ra_a;
  logic [AW-1:0] ra_b;
  logic [DW-1:0] rd_a;
  logic [DW-1:0] rd_b;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;
  logic [15:0]   commit_cnt;

  modport master (
    output wb_en, wb_addr, wb_data, stall, flush, ra_a, ra_b, dbg_addr,
    input  rd_a, rd_b, dbg_data, commit_cnt
  );

  modport slave (
    input  wb_en, wb_addr, wb_data, stall, flush, ra_a, ra_b, dbg_addr,
    output rd_a, rd_b, dbg_data, commit_cnt
  );
endinterface

// File: rtl/regfile_wb.sv
// Register-file write-back stage: 2^AW x DW array, one pending-write latch
// committing one edge after capture, bypassed onto both read ports.
module regfile_wb #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  regfile_wb_if.slave  bus
);
  localparam int NREG = 2 ** AW;

  logic [DW-1:0] regs [NREG];
  logic          p_v;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic [15:0]   cnt;
  logic          commit;

  // A held entry keeps committing while stalled; flush suppresses the commit.
  assign commit = p_v && (p_addr != '0) && !bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_v    <= 1'b0;
      p_addr <= '0;
      p_data <= '0;
      cnt    <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      if (bus.flush) begin
        p_v <= 1'b0;
      end else if (!bus.stall) begin
        p_v    <= bus.wb_en;
        p_addr <= bus.wb_addr;
        p_data <= bus.wb_data;
      end
      if (commit) begin
        regs[p_addr] <= p_data;
        cnt          <= cnt + 16'd1;
      end
    end
  end

  // Reads see only registered state; address 0 never matches the bypass.
  always_comb begin
    bus.rd_a = '0;
    if (bus.ra_a != '0)
      bus.rd_a = (p_v && p_addr == bus.ra_a) ? p_data : regs[bus.ra_a];
  end

  always_comb begin
    bus.rd_b = '0;
    if (bus.ra_b != '0)
      bus.rd_b = (p_v && p_addr == bus.ra_b) ? p_data : regs[bus.ra_b];
  end

  always_comb begin
    bus.dbg_data = '0;
    if (bus.dbg_addr != '0) bus.dbg_data = regs[bus.dbg_addr];
  end

  assign bus.commit_cnt = cnt;
endmodule

// File: tb/tb_regfile_wb.sv
// Directed-vector bench for regfile_wb: bypass, commit timing, flush/stall,
// asynchronous reset and commit-counter wrap.
module tb_regfile_wb;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  regfile_wb_if #(.DW(32), .AW(5)) bus ();
  regfile_wb #(.DW(32), .AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        stall;
    logic        flush;
    logic [4:0]  ra_a;
    logic [4:0]  ra_b;
    logic [4:0]  dbg_addr;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_dbg;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    bus.wb_en = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.stall = 1'b0; bus.flush = 1'b0;
    bus.ra_a = '0; bus.ra_b = '0; bus.dbg_addr = '0;
  endtask

  initial begin
    //            en addr data          st fl raA raB dbg  expA          expB          expDbg        cnt
    vt[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 1'b0, 5'd5, 5'd0,  5'd5,  32'hDEADBEEF, 32'h0,        32'h0,        16'd0};
    vt[1]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd5, 5'd5,  5'd5,  32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 16'd1};
    vt[2]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 1'b0, 5'd0, 5'd5,  5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        16'd1};
    vt[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd0, 5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        16'd1};
    vt[4]  = '{1'b1, 5'd7,  32'h11,       1'b0, 1'b0, 5'd5, 5'd7,  5'd7,  32'hDEADBEEF, 32'h11,       32'h0,        16'd1};
    vt[5]  = '{1'b1, 5'd7,  32'h22,       1'b0, 1'b0, 5'd5, 5'd7,  5'd7,  32'hDEADBEEF, 32'h22,       32'h11,       16'd2};
    vt[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd5, 5'd7,  5'd7,  32'hDEADBEEF, 32'h22,       32'h22,       16'd3};
    vt[7]  = '{1'b1, 5'd3,  32'hAA,       1'b0, 1'b0, 5'd3, 5'd7,  5'd3,  32'hAA,       32'h22,       32'h0,        16'd3};
    vt[8]  = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b1, 5'd3, 5'd7,  5'd3,  32'h0,        32'h22,       32'h0,        16'd3};
    vt[9]  = '{1'b1, 5'd4,  32'hBB,       1'b0, 1'b0, 5'd4, 5'd3,  5'd4,  32'hBB,       32'h0,        32'h0,        16'd3};
    vt[10] = '{1'b1, 5'd9,  32'h99,       1'b1, 1'b0, 5'd4, 5'd9,  5'd4,  32'hBB,       32'h0,        32'hBB,       16'd4};
    vt[11] = '{1'b1, 5'd9,  32'h99,       1'b1, 1'b0, 5'd4, 5'd9,  5'd4,  32'hBB,       32'h0,        32'hBB,       16'd5};
    vt[12] = '{1'b1, 5'd9,  32'h99,       1'b1, 1'b0, 5'd4, 5'd9,  5'd4,  32'hBB,       32'h0,        32'hBB,       16'd6};
    vt[13] = '{1'b1, 5'd9,  32'h99,       1'b1, 1'b1, 5'd4, 5'd9,  5'd4,  32'hBB,       32'h0,        32'hBB,       16'd6};
    vt[14] = '{1'b1, 5'd9,  32'h99,       1'b0, 1'b1, 5'd4, 5'd9,  5'd9,  32'hBB,       32'h0,        32'h0,        16'd6};
    vt[15] = '{1'b1, 5'd9,  32'h99,       1'b0, 1'b0, 5'd4, 5'd9,  5'd9,  32'hBB,       32'h99,       32'h0,        16'd6};
    vt[16] = '{1'b1, 5'd10, 32'h1010,     1'b0, 1'b0, 5'd9, 5'd10, 5'd9,  32'h99,       32'h1010,     32'h99,       16'd7};
    vt[17] = '{1'b0, 5'd0,  32'h0,        1'b0, 1'b0, 5'd9, 5'd10, 5'd10, 32'h99,       32'h1010,     32'h1010,     16'd8};

    idle_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    #1;
    chk("reset_cnt", {16'h0, bus.commit_cnt}, 32'h0);
    chk("reset_rd_a", bus.rd_a, 32'h0);
    chk("reset_dbg", bus.dbg_data, 32'h0);

    for (int i = 0; i < 18; i++) begin
      bus.wb_en = vt[i].wb_en; bus.wb_addr = vt[i].wb_addr; bus.wb_data = vt[i].wb_data;
      bus.stall = vt[i].stall; bus.flush = vt[i].flush;
      bus.ra_a = vt[i].ra_a; bus.ra_b = vt[i].ra_b; bus.dbg_addr = vt[i].dbg_addr;
      tick();
      chk($sformatf("v%0d_rd_a", i), bus.rd_a, vt[i].e_a);
      chk($sformatf("v%0d_rd_b", i), bus.rd_b, vt[i].e_b);
      chk($sformatf("v%0d_dbg", i), bus.dbg_data, vt[i].e_dbg);
      chk($sformatf("v%0d_cnt", i), {16'h0, bus.commit_cnt}, {16'h0, vt[i].e_cnt});
    end

    // No wb_* -> rd_* combinational path: pending-free r5 must read the array.
    idle_inputs();
    bus.ra_a = 5'd5;
    bus.wb_en = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h5555_5555;
    #1;
    chk("no_comb_path", bus.rd_a, 32'hDEADBEEF);

    // Mid-cycle reset with a write to r12 pending.
    bus.wb_addr = 5'd12; bus.wb_data = 32'hC0FFEE;
    tick();
    idle_inputs();
    bus.ra_a = 5'd12; bus.ra_b = 5'd5; bus.dbg_addr = 5'd7;
    #1;
    chk("pre_rst_bypass", bus.rd_a, 32'hC0FFEE);
    rst_n = 1'b0;
    #1;
    chk("rst_rd_a", bus.rd_a, 32'h0);
    chk("rst_rd_b", bus.rd_b, 32'h0);
    chk("rst_dbg", bus.dbg_data, 32'h0);
    chk("rst_cnt", {16'h0, bus.commit_cnt}, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.dbg_addr = 5'd12;
    #1;
    chk("post_rst_dbg", bus.dbg_data, 32'h0);
    chk("post_rst_cnt", {16'h0, bus.commit_cnt}, 32'h0);
    bus.wb_en = 1'b1; bus.wb_addr = 5'd2; bus.wb_data = 32'h2222;
    bus.ra_a = 5'd2;
    tick();
    chk("first_capture", bus.rd_a, 32'h2222);

    // Counter wrap: hold the r2 entry stalled so it commits every edge.
    bus.wb_en = 1'b0;
    bus.stall = 1'b1;
    for (int k = 0; k < 65535; k++) @(posedge clk);
    #2;
    chk("cnt_ffff", {16'h0, bus.commit_cnt}, 32'h0000_FFFF);
    tick();
    chk("cnt_wrap", {16'h0, bus.commit_cnt}, 32'h0);
    bus.dbg_addr = 5'd2;
    #1;
    chk("wrap_dbg", bus.dbg_data, 32'h2222);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
